// File: rtl/fxp_muldiv_seq.sv
// fxp_muldiv_seq
// Sequential signed fixed-point multiply/divide unit. One shift-add /
// restoring-division datapath is shared between the two operations, and the
// operation is selected per transaction. Operands and the result are two's
// complement. Each uses WI integer bits (sign included) and WF fraction bits.
//
// Ports
//   clk        single clock, all state on rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operands present
//   in_ready   unit idle and able to accept (decoded from state)
//   op         0 = ina*inb, 1 = ina/inb
//   ina        operand A / dividend   (WIIA.WIFA)
//   inb        operand B / divisor    (WIIB.WIFB)
//   out_valid  result held (decoded from state)
//   out_ready  consumer accepts the result
//   out        result                 (WOI.WOF)
//   overflow   result saturated, or divide by zero
module fxp_muldiv_seq #(
   parameter int WIIA  = 8,
   parameter int WIFA  = 8,
   parameter int WIIB  = 8,
   parameter int WIFB  = 8,
   parameter int WOI   = 8,
   parameter int WOF   = 8,
   parameter bit ROUND = 1'b1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op,
   input  logic [WIIA+WIFA-1:0] ina,
   input  logic [WIIB+WIFB-1:0] inb,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WOI+WOF-1:0]   out,
   output logic                 overflow
);

   localparam int WA    = WIIA + WIFA;
   localparam int WB    = WIIB + WIFB;
   localparam int WO    = WOI + WOF;
   // Magnitudes are one bit wider than the operands, so |min negative| is exact.
   localparam int MW    = ((WA > WB) ? WA : WB) + 1;
   localparam int N_MUL = WB;
   localparam int N_DIV = WO + 1;
   localparam int NMAX  = (N_DIV > N_MUL) ? N_DIV : N_MUL;
   localparam int CW    = $clog2(NMAX + 1);
   // Dividend alignment so the quotient carries WOF+1 fraction bits.
   localparam int SHD   = WIFB - WIFA + WOF + 1;
   localparam int SHD_L = (SHD > 0) ? SHD : 0;
   localparam int SHD_R = (SHD < 0) ? -SHD : 0;
   // Product alignment to WOF+1 fraction bits (the extra one is the round bit).
   localparam int SHM   = WIFA + WIFB - WOF - 1;
   localparam int MR    = (SHM > 0) ? SHM : 0;
   localparam int ML    = (SHM < 0) ? -SHM : 0;
   localparam int QW    = (N_DIV > MW) ? N_DIV : MW;
   localparam int XW0   = 2 * MW + ML;
   localparam int XW1   = MW + SHD_L;
   localparam int XW2   = MW + N_DIV + 1;
   localparam int XW01  = (XW0 > XW1) ? XW0 : XW1;
   localparam int XW    = (XW01 > XW2) ? XW01 : XW2;

   localparam logic [XW-1:0] POS_MAX = XW'((64'd1 << (WO - 1)) - 64'd1);
   localparam logic [XW-1:0] NEG_MAG = XW'(64'd1 << (WO - 1));
   localparam logic [WO-1:0] SAT_POS = {1'b0, {(WO-1){1'b1}}};
   localparam logic [WO-1:0] SAT_NEG = {1'b1, {(WO-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ITER, FIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            op_r, sign_r, ovf_pre;
   logic [XW-1:0]   acc;
   logic [XW-1:0]   opa;
   logic [QW-1:0]   opb;

   logic [MW-1:0]   a_ext, b_ext, mag_a, mag_b;
   logic [XW-1:0]   dividend_al, divisor_top, divisor_lim;
   logic [XW-1:0]   sum, diff;
   logic            geq;
   logic [XW-1:0]   mag_r, mag_rnd, mag_fin;
   logic [WO-1:0]   res_neg, res_fin;
   logic            ovf_fin;

   assign a_ext = {{(MW-WA){ina[WA-1]}}, ina};
   assign b_ext = {{(MW-WB){inb[WB-1]}}, inb};
   assign mag_a = ina[WA-1] ? -a_ext : a_ext;
   assign mag_b = inb[WB-1] ? -b_ext : b_ext;

   assign dividend_al = (XW'(mag_a) << SHD_L) >> SHD_R;
   assign divisor_top = XW'(mag_b) << (N_DIV - 1);
   assign divisor_lim = XW'(mag_b) << N_DIV;

   // The single adder/subtractor shared by both operations.
   assign sum  = acc + opa;
   assign diff = acc - opa;
   assign geq  = (acc >= opa);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode. ITER leaves once the count reaches zero.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid)          state_nxt = ITER;
         ITER: if (cnt == CW'(1))     state_nxt = FIN;
         FIN:                         state_nxt = DONE;
         DONE: if (out_ready)         state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Final alignment, rounding on the magnitude (ties away from zero),
   // sign application and saturation.
   always_comb begin
      mag_r   = op_r ? XW'(opb) : ((acc >> MR) << ML);
      mag_rnd = mag_r + XW'(ROUND);
      mag_fin = mag_rnd >> 1;
      res_neg = -mag_fin[WO-1:0];
      res_fin = sign_r ? res_neg : mag_fin[WO-1:0];
      ovf_fin = 1'b0;
      if (ovf_pre) begin
         res_fin = sign_r ? SAT_NEG : SAT_POS;
         ovf_fin = 1'b1;
      end else if (!sign_r && (mag_fin > POS_MAX)) begin
         res_fin = SAT_POS;
         ovf_fin = 1'b1;
      end else if (sign_r && (mag_fin > NEG_MAG)) begin
         res_fin = SAT_NEG;
         ovf_fin = 1'b1;
      end
   end

   // Datapath. Multiply keeps the multiplicand in opa (shifting left), the
   // multiplier in opb (shifting right) and the product in acc. Divide keeps
   // the remainder in acc, the divisor in opa (shifting right) and collects
   // quotient bits into opb. A zero divisor always trips the pre-check, so
   // divide by zero needs no separate path.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt      <= '0;
         op_r     <= 1'b0;
         sign_r   <= 1'b0;
         ovf_pre  <= 1'b0;
         acc      <= '0;
         opa      <= '0;
         opb      <= '0;
         out      <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_r   <= op;
                  sign_r <= ina[WA-1] ^ inb[WB-1];
                  if (op) begin
                     cnt     <= CW'(N_DIV);
                     acc     <= dividend_al;
                     opa     <= divisor_top;
                     opb     <= '0;
                     ovf_pre <= (dividend_al >= divisor_lim);
                  end else begin
                     cnt     <= CW'(N_MUL);
                     acc     <= '0;
                     opa     <= XW'(mag_a);
                     opb     <= QW'(mag_b);
                     ovf_pre <= 1'b0;
                  end
               end
            end
            ITER: begin
               cnt <= cnt - CW'(1);
               if (!op_r) begin
                  if (opb[0]) acc <= sum;
                  opa <= opa << 1;
                  opb <= opb >> 1;
               end else begin
                  if (geq) acc <= diff;
                  opa <= opa >> 1;
                  opb <= {opb[QW-2:0], geq};
               end
            end
            FIN: begin
               out      <= res_fin;
               overflow <= ovf_fin;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fxp_muldiv_seq.sv
// tb_fxp_muldiv_seq
// Bench for fxp_muldiv_seq with default formats (Q8.8 in/out). Two instances
// share the inputs and handshakes: one rounds (ROUND=1), one truncates
// (ROUND=0). Expected results are queued at acceptance and popped when the
// result is handed over.
module tb_fxp_muldiv_seq;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        op = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] ina = '0;
   logic [15:0] inb = '0;
   logic        in_ready, out_valid, overflow;
   logic        in_ready_t, out_valid_t, overflow_t;
   logic [15:0] out, out_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;

   typedef struct {
      logic [15:0] out_r;
      logic        ovf_r;
      logic [15:0] out_t;
      logic        ovf_t;
      int          lat;
   } exp_s;

   typedef struct {
      logic        opx;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] out_r;
      logic        ovf;
      logic [15:0] out_t;
   } vec_s;

   exp_s scoreboard[$];
   vec_s vecs[18];

   fxp_muldiv_seq #(.ROUND(1'b1)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .ina(ina), .inb(inb), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .overflow(overflow)
   );

   fxp_muldiv_seq #(.ROUND(1'b0)) dut_t (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
      .op(op), .ina(ina), .inb(inb), .out_valid(out_valid_t),
      .out_ready(out_ready), .out(out_t), .overflow(overflow_t)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, req);
      end
   endtask

   // Reference: integer arithmetic on magnitudes, Q8.8 in and out.
   function automatic logic [16:0] refModel(input logic opx, input logic [15:0] a,
                                            input logic [15:0] b, input bit rnd);
      longint sa, sbv, ma, mb, t, mag;
      bit neg;
      logic [15:0] r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      neg = (sa < 0) != (sbv < 0);
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sbv < 0) ? -sbv : sbv;
      if (opx && mb == 0) return {1'b1, (sa < 0) ? 16'h8000 : 16'h7FFF};
      if (!opx) t = (ma * mb) >>> 7;
      else      t = (ma * 512) / mb;
      mag = rnd ? ((t + 1) >>> 1) : (t >>> 1);
      if (!neg) begin
         if (mag > 32767) return {1'b1, 16'h7FFF};
         r = 16'(mag);
         return {1'b0, r};
      end
      if (mag > 32768) return {1'b1, 16'h8000};
      r = 16'(-mag);
      return {1'b0, r};
   endfunction

   function automatic logic [15:0] randOperand();
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 3))
         0: return r;
         1: return {{8{r[7]}}, r[7:0]};
         2: return {{4{r[11]}}, r[11:0]};
         default: return (r[0]) ? 16'h0000 : {{10{r[5]}}, r[5:0]};
      endcase
   endfunction

   // Present operands, wait (bounded) for acceptance, then scramble the
   // inputs since the unit must not rely on them after acceptance.
   task automatic applyStimulus(input logic opx, input logic [15:0] a,
                                input logic [15:0] b, input exp_s e);
      int k;
      @(negedge clk);
      op = opx; ina = a; inb = b; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("accept_ready", in_ready, 1);
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      ina = 16'($urandom);
      inb = 16'($urandom);
      op  = ~opx;
      scoreboard.push_back(e);
   endtask

   // Wait for the result, optionally stall the consumer (and poke in_valid
   // during the stall), then take the result and compare it.
   task automatic checkOutput(input int stall, input bit poke);
      exp_s e;
      int k;
      logic [15:0] held;
      logic        held_ovf;
      @(negedge clk);
      k = 0;
      while (!out_valid && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (scoreboard.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard: got empty want entry");
         return;
      end
      e = scoreboard.pop_front();
      check("latency", cyc - acc_cyc, e.lat);
      held = out;
      held_ovf = overflow;
      for (int s = 0; s < stall; s++) begin
         if (poke) begin
            op = 1'b0; ina = 16'h0100; inb = 16'h0100; in_valid = 1'b1;
         end
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
      end
      if (stall > 0) begin
         check("stall_out_stable", out, held);
         check("stall_ovf_stable", overflow, held_ovf);
         check("stall_valid_held", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("out_round", out, e.out_r);
      check("ovf_round", overflow, e.ovf_r);
      check("out_trunc", out_t, e.out_t);
      check("ovf_trunc", overflow_t, e.ovf_t);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("post_xfer_valid", out_valid, 0);
      check("post_xfer_ready", in_ready, 1);
   endtask

   initial begin
      exp_s e;
      logic [16:0] rr, rt;
      logic        rop;
      logic [15:0] ra, rb;

      vecs[0]  = '{1'b0, 16'h0180, 16'h0240, 16'h0360, 1'b0, 16'h0360};
      vecs[1]  = '{1'b1, 16'h0300, 16'hFF80, 16'hFA00, 1'b0, 16'hFA00};
      vecs[2]  = '{1'b1, 16'h0100, 16'h0300, 16'h0055, 1'b0, 16'h0055};
      vecs[3]  = '{1'b1, 16'h0200, 16'h0300, 16'h00AB, 1'b0, 16'h00AA};
      vecs[4]  = '{1'b0, 16'h6400, 16'h6400, 16'h7FFF, 1'b1, 16'h7FFF};
      vecs[5]  = '{1'b0, 16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 16'h7FFF};
      vecs[6]  = '{1'b1, 16'h0100, 16'h0000, 16'h7FFF, 1'b1, 16'h7FFF};
      vecs[7]  = '{1'b1, 16'hFF00, 16'h0000, 16'h8000, 1'b1, 16'h8000};
      vecs[8]  = '{1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16'h0000};
      vecs[9]  = '{1'b1, 16'h0000, 16'h0300, 16'h0000, 1'b0, 16'h0000};
      vecs[10] = '{1'b0, 16'h8000, 16'h0100, 16'h8000, 1'b0, 16'h8000};
      vecs[11] = '{1'b1, 16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 16'hFFAB};
      vecs[12] = '{1'b0, 16'h0001, 16'h0080, 16'h0001, 1'b0, 16'h0000};
      vecs[13] = '{1'b0, 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0, 16'h0000};
      vecs[14] = '{1'b1, 16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 16'h7FFF};
      vecs[15] = '{1'b1, 16'h8000, 16'h0100, 16'h8000, 1'b0, 16'h8000};
      vecs[16] = '{1'b1, 16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 16'h7FFF};
      vecs[17] = '{1'b1, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 16'h7FFF};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_overflow", overflow, 0);
      rstn = 1'b1;

      // Directed table.
      for (int i = 0; i < 18; i++) begin
         e.out_r = vecs[i].out_r;
         e.ovf_r = vecs[i].ovf;
         e.out_t = vecs[i].out_t;
         e.ovf_t = vecs[i].ovf;
         e.lat   = vecs[i].opx ? 18 : 17;
         applyStimulus(vecs[i].opx, vecs[i].a, vecs[i].b, e);
         checkOutput(i % 3, 1'b0);
      end

      // Consumer stalls 10 clocks while a new request is offered and ignored.
      $display("[TB] handshake stall sequence");
      e = '{16'h0360, 1'b0, 16'h0360, 1'b0, 17};
      applyStimulus(1'b0, 16'h0180, 16'h0240, e);
      checkOutput(10, 1'b1);
      repeat (3) @(negedge clk);
      check("no_ghost_result", out_valid, 0);

      // Reset five clocks into a divide aborts it at once.
      $display("[TB] reset mid-operation sequence");
      e = '{16'hFA00, 1'b0, 16'hFA00, 1'b0, 18};
      applyStimulus(1'b1, 16'h0300, 16'hFF80, e);
      repeat (5) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out", out, 0);
      scoreboard.delete();
      @(negedge clk);
      rstn = 1'b1;
      e = '{16'h0360, 1'b0, 16'h0360, 1'b0, 17};
      applyStimulus(1'b0, 16'h0180, 16'h0240, e);
      checkOutput(0, 1'b0);

      // Random operations with random consumer stalls.
      $display("[TB] random sequence");
      for (int n = 0; n < 200; n++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = randOperand();
         rb  = randOperand();
         rr  = refModel(rop, ra, rb, 1'b1);
         rt  = refModel(rop, ra, rb, 1'b0);
         e.out_r = rr[15:0];
         e.ovf_r = rr[16];
         e.out_t = rt[15:0];
         e.ovf_t = rt[16];
         e.lat   = rop ? 18 : 17;
         applyStimulus(rop, ra, rb, e);
         checkOutput($urandom_range(0, 4), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
